// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants and screen-coordinate type.
// Defaults describe 640x480 @ 60 Hz driven from a 50 MHz system clock.
package vga_timing_pkg;

   localparam int unsigned COORD_W = 10;

   // Screen coordinate as seen by the color mapper and sprite/tile lookup.
   typedef logic [COORD_W-1:0] coord_t;

   localparam int unsigned CLK_DIV_DEF   = 2;

   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FRONT_DEF   = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BACK_DEF    = 48;

   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FRONT_DEF   = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BACK_DEF    = 33;

   localparam int unsigned H_TOTAL      = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int unsigned V_TOTAL      = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
   localparam int unsigned H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
   localparam int unsigned V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

   // Inclusive range test used for the sync pulse windows.
   function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel cadence: divides Clk by CLK_DIV, producing the pixel-advance tick
// and a registered pixel clock whose rising edge sits mid-pixel.
module vga_pixel_div
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV = CLK_DIV_DEF
)
(
   input  logic Clk,
   input  logic Reset,
   output logic pix_tick,
   output logic VGA_CLK
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF_C = DIV_W'(CLK_DIV / 2);

   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] div_nxt_s;
   logic             pix_tick_r;
   logic             vga_clk_r;

   // Next divider value: wrap by compare at CLK_DIV-1.
   always_comb begin
      div_nxt_s = div_r;
      if (div_r == DIV_LAST_C) begin
         div_nxt_s = DIV_W'(0);
      end else begin
         div_nxt_s = div_r + DIV_W'(1);
      end
   end

   // Divider state plus tick/clock registers derived from the next divider value.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_r      <= DIV_W'(0);
         pix_tick_r <= 1'b0;
         vga_clk_r  <= 1'b0;
      end else begin
         div_r      <= div_nxt_s;
         pix_tick_r <= (div_nxt_s == DIV_LAST_C);
         vga_clk_r  <= (div_nxt_s >= DIV_HALF_C);
      end
   end

   assign pix_tick = pix_tick_r;
   assign VGA_CLK  = vga_clk_r;

endmodule

// File: rtl/vga_scan_generator.sv
// Raster scan generator: horizontal/vertical counters, zero-skew sync and
// blank registers, and a frame-done strobe at entry to vertical blanking.
module vga_scan_generator
   import vga_timing_pkg::*;
#(
   parameter int unsigned CLK_DIV   = CLK_DIV_DEF,
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FRONT   = H_FRONT_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BACK    = H_BACK_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FRONT   = V_FRONT_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BACK    = V_BACK_DEF
)
(
   input  logic   Clk,
   input  logic   Reset,
   output coord_t DrawX,
   output coord_t DrawY,
   output logic   VGA_CLK,
   output logic   VGA_HS,
   output logic   VGA_VS,
   output logic   VGA_BLANK_N,
   output logic   VGA_SYNC_N,
   output logic   pix_tick,
   output logic   frame_done
);

   localparam coord_t H_LAST_C     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam coord_t V_LAST_C     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam coord_t H_VIS_C      = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C      = coord_t'(V_VISIBLE);
   localparam coord_t V_VIS_LAST_C = coord_t'(V_VISIBLE - 1);
   localparam coord_t HS_START_C   = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END_C     = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_START_C   = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END_C     = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic   pix_tick_s;
   logic   vga_clk_s;
   coord_t hc_r;
   coord_t vc_r;
   coord_t hc_nxt_s;
   coord_t vc_nxt_s;
   logic   frame_entry_s;
   logic   hs_r;
   logic   vs_r;
   logic   blank_n_r;
   logic   frame_done_r;

   vga_pixel_div #(
      .CLK_DIV (CLK_DIV)
   ) u_pixel_div (
      .Clk      (Clk),
      .Reset    (Reset),
      .pix_tick (pix_tick_s),
      .VGA_CLK  (vga_clk_s)
   );

   // Next-state scan counters; vc moves only on the edge where hc wraps.
   always_comb begin
      hc_nxt_s = hc_r;
      vc_nxt_s = vc_r;
      if (pix_tick_s) begin
         if (hc_r == H_LAST_C) begin
            hc_nxt_s = coord_t'(0);
            if (vc_r == V_LAST_C) begin
               vc_nxt_s = coord_t'(0);
            end else begin
               vc_nxt_s = vc_r + coord_t'(1);
            end
         end else begin
            hc_nxt_s = hc_r + coord_t'(1);
            vc_nxt_s = vc_r;
         end
      end else begin
         hc_nxt_s = hc_r;
         vc_nxt_s = vc_r;
      end
   end

   // Leaving the last visible pixel of the last visible line enters vertical blanking.
   assign frame_entry_s = pix_tick_s && (hc_r == H_LAST_C) && (vc_r == V_VIS_LAST_C);

   // Counters and sync/blank registers, all updated from next-state values so they move together.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hc_r         <= coord_t'(0);
         vc_r         <= coord_t'(0);
         hs_r         <= 1'b1;
         vs_r         <= 1'b1;
         blank_n_r    <= 1'b1;
         frame_done_r <= 1'b0;
      end else begin
         hc_r         <= hc_nxt_s;
         vc_r         <= vc_nxt_s;
         hs_r         <= ~in_range(hc_nxt_s, HS_START_C, HS_END_C);
         vs_r         <= ~in_range(vc_nxt_s, VS_START_C, VS_END_C);
         blank_n_r    <= (hc_nxt_s < H_VIS_C) && (vc_nxt_s < V_VIS_C);
         frame_done_r <= frame_entry_s;
      end
   end

   assign DrawX       = hc_r;
   assign DrawY       = vc_r;
   assign VGA_CLK     = vga_clk_s;
   assign VGA_HS      = hs_r;
   assign VGA_VS      = vs_r;
   assign VGA_BLANK_N = blank_n_r;
   assign VGA_SYNC_N  = 1'b0;
   assign pix_tick    = pix_tick_s;
   assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Bench for vga_scan_generator: one default-timing instance and two
// reduced-timing instances (CLK_DIV 4 and 2) so whole frames fit a short run.
module tb_vga_scan_generator;

   localparam int SHV = 20, SHF = 3, SHS = 5, SHB = 4;
   localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
   localparam int NV  = 11;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vclk;
      logic       hs;
      logic       vs;
      logic       bn;
      logic       sn;
      logic       pt;
      logic       fd;
   } exp_t;

   typedef struct {
      int   t;
      int   x;
      int   y;
      logic hs;
      logic bn;
   } vec_t;

   logic       Clk;
   logic       rst  [3];
   logic [9:0] dx   [3];
   logic [9:0] dy   [3];
   logic       vclk [3];
   logic       hs   [3];
   logic       vs   [3];
   logic       bn   [3];
   logic       sn   [3];
   logic       pt   [3];
   logic       fd   [3];

   int     D[3], HV[3], HF[3], HSY[3], HB[3], VV[3], VF[3], VSY[3], VB[3];
   longint t[3];
   logic   armed[3];
   int     win[3];
   int     hold[3];
   logic   metrics_on;
   int     fd_cnt[3], fd_first[3], fd_gap[3], fd_prev[3], fd_bad[3];
   int     vs_low[3], hs_low[3], bn_low[3], ymax[3];
   vec_t   tbl[NV];
   logic   seen[NV];
   int     vectors;
   int     miscompares;

   vga_scan_generator dut_a (
      .Clk(Clk), .Reset(rst[0]), .DrawX(dx[0]), .DrawY(dy[0]), .VGA_CLK(vclk[0]),
      .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bn[0]), .VGA_SYNC_N(sn[0]),
      .pix_tick(pt[0]), .frame_done(fd[0])
   );

   vga_scan_generator #(
      .CLK_DIV(4), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
   ) dut_b (
      .Clk(Clk), .Reset(rst[1]), .DrawX(dx[1]), .DrawY(dy[1]), .VGA_CLK(vclk[1]),
      .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bn[1]), .VGA_SYNC_N(sn[1]),
      .pix_tick(pt[1]), .frame_done(fd[1])
   );

   vga_scan_generator #(
      .CLK_DIV(2), .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
   ) dut_c (
      .Clk(Clk), .Reset(rst[2]), .DrawX(dx[2]), .DrawY(dy[2]), .VGA_CLK(vclk[2]),
      .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bn[2]), .VGA_SYNC_N(sn[2]),
      .pix_tick(pt[2]), .frame_done(fd[2])
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Reference raster: position follows from elapsed cycles since reset release.
   function automatic exp_t model(input int k, input longint tt);
      longint ht, vt, n, ph, hc, vc;
      exp_t   e;
      ht = HV[k] + HF[k] + HSY[k] + HB[k];
      vt = VV[k] + VF[k] + VSY[k] + VB[k];
      ph = tt % D[k];
      n  = tt / D[k];
      hc = n % ht;
      vc = (n / ht) % vt;
      e.x    = 10'(hc);
      e.y    = 10'(vc);
      e.vclk = (ph >= D[k] / 2);
      e.pt   = (ph == D[k] - 1);
      e.hs   = !(hc >= HV[k] + HF[k] && hc < HV[k] + HF[k] + HSY[k]);
      e.vs   = !(vc >= VV[k] + VF[k] && vc < VV[k] + VF[k] + VSY[k]);
      e.bn   = (hc < HV[k]) && (vc < VV[k]);
      e.sn   = 1'b0;
      e.fd   = (tt > 0) && (ph == 0) && ((n % (ht * vt)) == ht * VV[k]);
      return e;
   endfunction

   function automatic exp_t sample(input int k);
      exp_t a;
      a = {dx[k], dy[k], vclk[k], hs[k], vs[k], bn[k], sn[k], pt[k], fd[k]};
      return a;
   endfunction

   task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input exp_t act, input exp_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got x=%0d y=%0d bits=%b, expected x=%0d y=%0d bits=%b",
                  name, act.x, act.y, act[6:0], exp.x, exp.y, exp[6:0]);
      end
   endtask

   // One clock: advance elapsed-cycle counters at the edge, compare at the falling edge.
   task automatic step();
      exp_t a;
      @(posedge Clk);
      for (int k = 0; k < 3; k++) begin
         if (rst[k]) begin
            t[k] = 0;
            armed[k] = 1'b1;
         end else begin
            t[k]++;
         end
      end
      @(negedge Clk);
      for (int k = 0; k < 3; k++) begin
         if (armed[k]) begin
            a = sample(k);
            check_state($sformatf("model_dut%0d_t%0d", k, t[k]), a, model(k, t[k]));
            if (metrics_on && t[k] < win[k]) begin
               if (a.fd) begin
                  if (fd_cnt[k] == 0) fd_first[k] = int'(t[k]);
                  else fd_gap[k] = int'(t[k]) - fd_prev[k];
                  fd_prev[k] = int'(t[k]);
                  fd_cnt[k]++;
                  if (a.bn || a.x != 10'd0 || a.y != 10'(VV[k])) fd_bad[k]++;
               end
               if (!a.vs) vs_low[k]++;
               if (!a.hs) hs_low[k]++;
               if (!a.bn) bn_low[k]++;
               if (int'(a.y) > ymax[k]) ymax[k] = int'(a.y);
            end
         end
      end
      if (armed[0]) begin
         for (int i = 0; i < NV; i++) begin
            if (t[0] == longint'(tbl[i].t)) begin
               seen[i] = 1'b1;
               check_vec($sformatf("table_t%0d", tbl[i].t),
                         {10'd0, dx[0], dy[0], hs[0], bn[0]},
                         {10'd0, 10'(tbl[i].x), 10'(tbl[i].y), tbl[i].hs, tbl[i].bn});
            end
         end
      end
   endtask

   initial begin
      exp_t rst_exp;
      vectors = 0;
      miscompares = 0;
      metrics_on = 1'b0;
      D   = '{2, 4, 2};
      HV  = '{640, SHV, SHV};  HF = '{16, SHF, SHF};  HSY = '{96, SHS, SHS};  HB = '{48, SHB, SHB};
      VV  = '{480, SVV, SVV};  VF = '{10, SVF, SVF};  VSY = '{2, SVS, SVS};    VB = '{33, SVB, SVB};

      tbl[0]  = '{0,    0,   0, 1'b1, 1'b1};
      tbl[1]  = '{1,    0,   0, 1'b1, 1'b1};
      tbl[2]  = '{2,    1,   0, 1'b1, 1'b1};
      tbl[3]  = '{1279, 639, 0, 1'b1, 1'b1};
      tbl[4]  = '{1280, 640, 0, 1'b1, 1'b0};
      tbl[5]  = '{1311, 655, 0, 1'b1, 1'b0};
      tbl[6]  = '{1312, 656, 0, 1'b0, 1'b0};
      tbl[7]  = '{1503, 751, 0, 1'b0, 1'b0};
      tbl[8]  = '{1504, 752, 0, 1'b1, 1'b0};
      tbl[9]  = '{1598, 799, 0, 1'b1, 1'b0};
      tbl[10] = '{1600, 0,   1, 1'b1, 1'b1};

      for (int i = 0; i < NV; i++) seen[i] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; armed[k] = 1'b0; t[k] = 0; hold[k] = 0;
         fd_cnt[k] = 0; fd_first[k] = -1; fd_gap[k] = -1; fd_prev[k] = 0; fd_bad[k] = 0;
         vs_low[k] = 0; hs_low[k] = 0; bn_low[k] = 0; ymax[k] = 0;
      end
      win[0] = 1600;
      win[1] = 2 * (32 * 19 * 4) + 8;
      win[2] = 2 * (32 * 19 * 2) + 8;

      // Reset all instances, then scan two small frames and one default line.
      step();
      step();
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      metrics_on = 1'b1;
      for (int i = 0; i < win[1]; i++) step();
      metrics_on = 1'b0;

      for (int i = 0; i < NV; i++) check_vec($sformatf("table_seen_%0d", i), {31'd0, seen[i]}, 32'd1);
      check_vec("hs_low_clk_per_line", hs_low[0], 32'd192);
      check_vec("blank_low_clk_line0", bn_low[0], 32'd320);
      for (int k = 1; k < 3; k++) begin
         check_vec($sformatf("fd_count_dut%0d", k), fd_cnt[k], 32'd2);
         check_vec($sformatf("fd_first_dut%0d", k), fd_first[k], 32'(32 * SVV * D[k]));
         check_vec($sformatf("fd_period_dut%0d", k), fd_gap[k], 32'(32 * 19 * D[k]));
         check_vec($sformatf("fd_placement_dut%0d", k), fd_bad[k], 32'd0);
         check_vec($sformatf("vs_low_clk_dut%0d", k), vs_low[k], 32'(2 * SVS * 32 * D[k]));
         check_vec($sformatf("ymax_dut%0d", k), ymax[k], 32'd18);
      end

      // Mid-line, mid-pixel reset on the default instance at DrawX=300.
      for (int i = 0; i < 1700 && (t[0] % 1600) != 601; i++) step();
      check_vec("pre_reset_drawx", {22'd0, dx[0]}, 32'd300);
      rst[0] = 1'b1;
      step();
      rst_exp = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      check_state("reset_state", sample(0), rst_exp);
      rst[0] = 1'b0;
      step();
      step();
      check_vec("post_reset_drawx", {22'd0, dx[0]}, 32'd1);

      // Random resets on the reduced-timing instances, checked against the model.
      for (int i = 0; i < 3000; i++) begin
         for (int k = 1; k < 3; k++) begin
            if (rst[k]) begin
               if (hold[k] > 0) hold[k]--;
               else rst[k] = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
               rst[k] = 1'b1;
               hold[k] = int'($urandom_range(0, 2));
            end
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
